// File: rtl/fir_int2_pkg.sv
// Shared types and arithmetic helpers for the FIR family (interpolator and 4-tap decimator).
package fir_pkg;

    localparam int unsigned W_IN_DEF   = 8;
    localparam int unsigned GUARD_BITS = 4;
    // Working width for the shared helpers; callers sign-extend into it and truncate back out.
    localparam int unsigned W_FN       = 32;

    typedef enum logic [1:0] {
        S_IN   = 2'd0,
        S_CALC = 2'd1,
        S_A    = 2'd2,
        S_B    = 2'd3
    } state_e;

    // 3.75*t as 2t + t + t/2 + t/4, each term floored toward -inf.
    function automatic logic signed [W_FN-1:0] shift_add_375(input logic signed [W_FN-1:0] t);
        return (t <<< 1) + t + (t >>> 1) + (t >>> 2);
    endfunction

endpackage

// File: rtl/fir_int2_if.sv
// Input/output streaming bus of the interpolate-by-2 FIR.
// Optional port hold exists only when FIR_INT2_HOLD_EN is defined.
interface fir_int2_if
    import fir_pkg::*;
#(
    parameter int unsigned W_IN  = W_IN_DEF,
    parameter int unsigned W_OUT = W_IN + GUARD_BITS
) ();

    logic signed [W_IN-1:0]  x;
    logic                    x_valid;
    logic                    x_ready;
    logic signed [W_OUT-1:0] y;
    logic                    y_valid;
    logic                    y_ready;
    logic                    y_phase;
`ifdef FIR_INT2_HOLD_EN
    logic                    hold;
`endif

    // Upstream producer / downstream consumer side
    modport master (
        output x, x_valid, y_ready,
`ifdef FIR_INT2_HOLD_EN
        output hold,
`endif
        input  x_ready, y, y_valid, y_phase
    );

    // Filter side
    modport slave (
        input  x, x_valid, y_ready,
`ifdef FIR_INT2_HOLD_EN
        input  hold,
`endif
        output x_ready, y, y_valid, y_phase
    );

endinterface

// File: rtl/fir_int2_mac.sv
// Combinational phase A / phase B computation from the four taps.
module fir_int2_mac
    import fir_pkg::*;
#(
    parameter int unsigned W_IN  = W_IN_DEF,
    parameter int unsigned W_OUT = W_IN + GUARD_BITS
) (
    input  logic signed [W_IN-1:0]  t0,
    input  logic signed [W_IN-1:0]  t1,
    input  logic signed [W_IN-1:0]  t2,
    input  logic signed [W_IN-1:0]  t3,
    output logic signed [W_OUT-1:0] a_c,
    output logic signed [W_OUT-1:0] b_c
);

    logic signed [W_FN-1:0] e0, e1, e2, e3;
    logic signed [W_FN-1:0] a_w, b_w;

    // Sign-extend, apply [-1 3.75 3.75 -1] and 5.5*t1, then narrow (results always fit W_OUT).
    always_comb begin
        e0  = W_FN'(t0);
        e1  = W_FN'(t1);
        e2  = W_FN'(t2);
        e3  = W_FN'(t3);
        a_w = shift_add_375(e1) + shift_add_375(e2) - e0 - e3;
        b_w = (e1 <<< 2) + e1 + (e1 >>> 1);
        a_c = W_OUT'(a_w);
        b_c = W_OUT'(b_w);
    end

endmodule

// File: rtl/fir_int2.sv
// Polyphase interpolate-by-2 FIR: each accepted sample yields phase A then phase B.
// Optional zero-order-hold mode enabled by FIR_INT2_HOLD_EN.
module fir_int2
    import fir_pkg::*;
#(
    parameter int unsigned W_IN  = W_IN_DEF,
    parameter int unsigned W_OUT = W_IN + GUARD_BITS
) (
    input  logic        clk,
    input  logic        reset_n,
    fir_int2_if.slave   bus
);

    state_e                  state_q, state_d;
    logic signed [W_IN-1:0]  tap_q [4];
    logic signed [W_IN-1:0]  tap_d [4];
    logic signed [W_OUT-1:0] y_q, y_d;
    logic signed [W_OUT-1:0] b_hold_q, b_hold_d;
    logic                    y_valid_q, y_valid_d;
    logic                    y_phase_q, y_phase_d;
    logic                    x_ready_q, x_ready_d;
    logic signed [W_OUT-1:0] a_c, b_c;

    fir_int2_mac #(.W_IN(W_IN), .W_OUT(W_OUT)) u_mac (
        .t0  (tap_q[0]),
        .t1  (tap_q[1]),
        .t2  (tap_q[2]),
        .t3  (tap_q[3]),
        .a_c (a_c),
        .b_c (b_c)
    );

    // Next-state, tap line and output register computation
    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        y_d       = y_q;
        b_hold_d  = b_hold_q;
        y_valid_d = y_valid_q;
        y_phase_d = y_phase_q;
        unique case (state_q)
            S_IN: begin
                if (bus.x_valid) begin
                    tap_d[3] = tap_q[2];
                    tap_d[2] = tap_q[1];
                    tap_d[1] = tap_q[0];
                    tap_d[0] = bus.x;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
`ifdef FIR_INT2_HOLD_EN
                y_d = bus.hold ? b_c : a_c;
`else
                y_d = a_c;
`endif
                b_hold_d  = b_c;
                y_phase_d = 1'b0;
                y_valid_d = 1'b1;
                state_d   = S_A;
            end
            S_A: begin
                if (bus.y_ready) begin
                    y_d       = b_hold_q;
                    y_phase_d = 1'b1;
                    state_d   = S_B;
                end
            end
            S_B: begin
                if (bus.y_ready) begin
                    y_valid_d = 1'b0;
                    y_phase_d = 1'b0;
                    state_d   = S_IN;
                end
            end
            default: state_d = S_IN;
        endcase
        // Registered ready depends only on our own state, never on y_ready combinationally.
        x_ready_d = (state_d == S_IN);
    end

    // State, taps and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IN;
            tap_q     <= '{default: '0};
            y_q       <= '0;
            b_hold_q  <= '0;
            y_valid_q <= 1'b0;
            y_phase_q <= 1'b0;
            x_ready_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            tap_q     <= tap_d;
            y_q       <= y_d;
            b_hold_q  <= b_hold_d;
            y_valid_q <= y_valid_d;
            y_phase_q <= y_phase_d;
            x_ready_q <= x_ready_d;
        end
    end

    assign bus.x_ready = x_ready_q;
    assign bus.y       = y_q;
    assign bus.y_valid = y_valid_q;
    assign bus.y_phase = y_phase_q;

endmodule

// File: tb/tb_fir_int2.sv
// Directed self-checking bench for fir_int2 (hold test built when FIR_INT2_HOLD_EN is defined).
module tb_fir_int2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    fir_int2_if #(.W_IN(8), .W_OUT(12)) bus ();

    fir_int2 #(.W_IN(8), .W_OUT(12)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        reset_n      = 1'b0;
        bus.x        = '0;
        bus.x_valid  = 1'b0;
        bus.y_ready  = 1'b1;
`ifdef FIR_INT2_HOLD_EN
        bus.hold     = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Push one sample with y_ready=1 and capture both output phases; ok=0 on timeout.
    task automatic run_sample(input logic signed [7:0] xv, input logic hv,
                              output logic signed [11:0] a, output logic pa,
                              output logic signed [11:0] b, output logic pb,
                              output logic ok);
        int n;
        ok = 1'b1; a = '0; b = '0; pa = 1'b0; pb = 1'b0;
        bus.y_ready = 1'b1;
        bus.x       = xv;
        bus.x_valid = 1'b1;
`ifdef FIR_INT2_HOLD_EN
        bus.hold    = hv;
`else
        if (hv) ;
`endif
        @(posedge clk); #1;
        bus.x_valid = 1'b0;
        n = 0;
        while (!bus.y_valid && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.y_valid) begin
            ok = 1'b0;
        end else begin
            a  = bus.y;
            pa = bus.y_phase;
            @(posedge clk); #1;
            b  = bus.y;
            pb = bus.y_phase;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.y !== 12'sd0) begin errors++; $display("FAIL reset_y got %0d want 0", bus.y); end
        checks++;
        if (bus.y_valid !== 1'b0) begin errors++; $display("FAIL reset_y_valid got %b want 0", bus.y_valid); end
        checks++;
        if (bus.y_phase !== 1'b0) begin errors++; $display("FAIL reset_y_phase got %b want 0", bus.y_phase); end
        checks++;
        if (bus.x_ready !== 1'b1) begin errors++; $display("FAIL reset_x_ready got %b want 1", bus.x_ready); end
    endtask

    // Run a 5-sample directed sequence from reset and compare every (A,B) pair.
    task automatic test_sequence(input string name, input logic signed [7:0] xs [5],
                                 input logic signed [11:0] ea [5], input logic signed [11:0] eb [5],
                                 input int first, input logic hv);
        logic signed [11:0] a, b;
        logic pa, pb, ok;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_sample(xs[i], hv, a, pa, b, pb, ok);
            if (i >= first) begin
                checks++;
                if (!ok) begin
                    errors++; $display("FAIL %s[%0d] timeout waiting y_valid", name, i);
                end else begin
                    checks += 3;
                    if (a !== ea[i]) begin errors++; $display("FAIL %s[%0d] A got %0d want %0d", name, i, a, ea[i]); end
                    if (b !== eb[i]) begin errors++; $display("FAIL %s[%0d] B got %0d want %0d", name, i, b, eb[i]); end
                    if (pa !== 1'b0 || pb !== 1'b1) begin
                        errors++; $display("FAIL %s[%0d] phases got %b%b want 01", name, i, pa, pb);
                    end
                end
            end
        end
    endtask

    task automatic test_constant();
        logic signed [7:0]  xs [5] = '{8'sd4, 8'sd4, 8'sd4, 8'sd4, 8'sd4};
        logic signed [11:0] ea [5] = '{-12'sd4, 12'sd11, 12'sd26, 12'sd22, 12'sd22};
        logic signed [11:0] eb [5] = '{12'sd0, 12'sd22, 12'sd22, 12'sd22, 12'sd22};
        test_sequence("constant", xs, ea, eb, 0, 1'b0);
    endtask

    task automatic test_impulse();
        logic signed [7:0]  xs [5] = '{8'sd64, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
        logic signed [11:0] ea [5] = '{-12'sd64, 12'sd240, 12'sd240, -12'sd64, 12'sd0};
        logic signed [11:0] eb [5] = '{12'sd0, 12'sd352, 12'sd0, 12'sd0, 12'sd0};
        test_sequence("impulse", xs, ea, eb, 0, 1'b0);
    endtask

    task automatic test_negative_floor();
        logic signed [7:0]  xs [5] = '{-8'sd3, -8'sd3, -8'sd3, -8'sd3, -8'sd3};
        logic signed [11:0] ea [5] = '{12'sd3, -12'sd9, -12'sd21, -12'sd18, -12'sd18};
        logic signed [11:0] eb [5] = '{12'sd0, -12'sd17, -12'sd17, -12'sd17, -12'sd17};
        test_sequence("neg_floor", xs, ea, eb, 0, 1'b0);
    endtask

    // Stall in S_A and S_B; stray x_valid during the stall must be ignored.
    task automatic test_backpressure();
        logic signed [11:0] a, b;
        logic pa, pb, ok;
        do_reset();
        run_sample(8'sd64, 1'b0, a, pa, b, pb, ok);
        bus.y_ready = 1'b0;
        bus.x = 8'sd0; bus.x_valid = 1'b1;
        @(posedge clk); #1;
        bus.x = 8'sd99;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.y !== 12'sd240 || bus.y_phase !== 1'b0 || bus.y_valid !== 1'b1 || bus.x_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall_A cyc%0d got y=%0d ph=%b v=%b xr=%b want 240 0 1 0",
                         i, bus.y, bus.y_phase, bus.y_valid, bus.x_ready);
            end
            @(posedge clk); #1;
        end
        bus.y_ready = 1'b1;
        @(posedge clk); #1;
        bus.y_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.y !== 12'sd352 || bus.y_phase !== 1'b1 || bus.y_valid !== 1'b1 || bus.x_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall_B cyc%0d got y=%0d ph=%b v=%b xr=%b want 352 1 1 0",
                         i, bus.y, bus.y_phase, bus.y_valid, bus.x_ready);
            end
            @(posedge clk); #1;
        end
        bus.x_valid = 1'b0;
        bus.y_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.y_valid !== 1'b0 || bus.x_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release got v=%b xr=%b want 0 1", bus.y_valid, bus.x_ready);
        end
        run_sample(8'sd0, 1'b0, a, pa, b, pb, ok);
        checks++;
        if (!ok || a !== 12'sd240 || b !== 12'sd0) begin
            errors++; $display("FAIL bp_next ok=%b got A=%0d B=%0d want 240 0", ok, a, b);
        end
    endtask

    // Async reset while presenting phase A; taps must clear.
    task automatic test_reset_mid_pair();
        logic signed [11:0] a, b;
        logic pa, pb, ok;
        do_reset();
        run_sample(8'sd64, 1'b0, a, pa, b, pb, ok);
        bus.y_ready = 1'b0;
        bus.x = 8'sd64; bus.x_valid = 1'b1;
        @(posedge clk); #1;
        bus.x_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.y_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got v=%b want 1", bus.y_valid); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.y_valid !== 1'b0 || bus.y !== 12'sd0 || bus.x_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_async got v=%b y=%0d xr=%b want 0 0 1", bus.y_valid, bus.y, bus.x_ready);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        run_sample(8'sd64, 1'b0, a, pa, b, pb, ok);
        checks++;
        if (!ok || a !== -12'sd64 || b !== 12'sd0) begin
            errors++; $display("FAIL rst_mid_after ok=%b got A=%0d B=%0d want -64 0", ok, a, b);
        end
    endtask

`ifdef FIR_INT2_HOLD_EN
    task automatic test_hold();
        logic signed [7:0]  xs [5] = '{8'sd64, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
        logic signed [11:0] ea [5] = '{12'sd0, 12'sd352, 12'sd0, 12'sd0, 12'sd0};
        logic signed [11:0] eb [5] = '{12'sd0, 12'sd352, 12'sd0, 12'sd0, 12'sd0};
        test_sequence("hold", xs, ea, eb, 0, 1'b1);
    endtask
`endif

    initial begin
        bus.x = '0; bus.x_valid = 1'b0; bus.y_ready = 1'b1;
`ifdef FIR_INT2_HOLD_EN
        bus.hold = 1'b0;
`endif
        test_reset();
        test_constant();
        test_impulse();
        test_negative_floor();
        test_backpressure();
        test_reset_mid_pair();
`ifdef FIR_INT2_HOLD_EN
        test_hold();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
